// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM address-learning controller: FSM encoding,
// write-type qualifiers and the saturated age value.
package cam_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WRITE  = 3'd2,
    S_WAIT   = 3'd3,
    S_AGE    = 3'd4,
    S_SCAN   = 3'd5
  } state_e;

  localparam logic WR_LEARN  = 1'b0;
  localparam logic WR_DELETE = 1'b1;

  // Freshly learned or refreshed entries start at the top of the age range.
  function automatic int age_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module cam_prio_enc #(
  parameter int W  = 32,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Descending scan so the lowest set bit is the last assignment to stick.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_learn_ctrl.sv
// MAC learning and aging controller: sequences CAM compare/write ports and
// owns the per-entry valid, age and port state.
module cam_learn_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 48,
  parameter int ADDR_WIDTH    = 5,
  parameter int PORT_WIDTH    = 2,
  parameter int AGE_WIDTH     = 3,
  parameter int MATCH_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     learn_valid,
  output logic                     learn_ready,
  input  logic [DATA_WIDTH-1:0]    learn_mac,
  input  logic [PORT_WIDTH-1:0]    learn_port,
  input  logic                     age_tick,
  output logic [ADDR_WIDTH-1:0]    cam_write_addr,
  output logic [DATA_WIDTH-1:0]    cam_write_data,
  output logic                     cam_write_delete,
  output logic                     cam_write_enable,
  input  logic                     cam_write_busy,
  output logic [DATA_WIDTH-1:0]    cam_compare_data,
  input  logic [2**ADDR_WIDTH-1:0] cam_match_many,
  output logic [2**ADDR_WIDTH-1:0] entry_valid,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [PORT_WIDTH-1:0]    rd_port,
  output logic                     busy
);

  localparam int N  = 2**ADDR_WIDTH;
  localparam int LW = (MATCH_LATENCY > 1) ? $clog2(MATCH_LATENCY) : 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(age_max(AGE_WIDTH));
  localparam int ENC_HIT = 0, ENC_FREE = 1, ENC_EXP = 2;

  state_e                           state_q, state_d;
  logic [N-1:0]                     valid_q, expired_q, hit_vec, age_zero;
  logic [N-1:0][AGE_WIDTH-1:0]      age_q;
  logic [N-1:0][PORT_WIDTH-1:0]     port_q;
  logic [ADDR_WIDTH-1:0]            victim_q, tgt_q;
  logic                             age_pend_q, del_q;
  logic [DATA_WIDTH-1:0]            mac_q, cmp_q;
  logic [PORT_WIDTH-1:0]            pcap_q;
  logic [LW-1:0]                    lat_q;
  logic                             lat_done, ready_c, accept, wr_en;

  logic [2:0][N-1:0]                enc_vec;
  logic [2:0][ADDR_WIDTH-1:0]       enc_idx;
  logic [2:0]                       enc_found;

  // Stale CAM keys at invalid slots are masked out here.
  assign hit_vec = cam_match_many & valid_q;
  assign enc_vec = {expired_q, ~valid_q, hit_vec};

  for (genvar g = 0; g < 3; g++) begin : g_enc
    cam_prio_enc #(.W(N), .IW(ADDR_WIDTH)) u_enc (
      .vec   (enc_vec[g]),
      .idx   (enc_idx[g]),
      .found (enc_found[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N; i++) age_zero[i] = (age_q[i] == '0);
  end

  assign lat_done = (lat_q == LW'(MATCH_LATENCY - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (age_pend_q) state_d = S_AGE;
        else begin
          // A tick in this very cycle already outranks a new learn.
          ready_c = !age_tick;
          if (learn_valid && !age_tick) state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: if (lat_done) state_d = enc_found[ENC_HIT] ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (!cam_write_busy) begin
          wr_en   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT:  if (!cam_write_busy) state_d = del_q ? S_SCAN : S_IDLE;
      S_AGE:   state_d = S_SCAN;
      S_SCAN:  state_d = enc_found[ENC_EXP] ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign learn_ready = rst & ready_c;
  assign accept      = learn_valid & learn_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      expired_q  <= '0;
      age_q      <= '0;
      port_q     <= '0;
      victim_q   <= '0;
      tgt_q      <= '0;
      age_pend_q <= 1'b0;
      del_q      <= WR_LEARN;
      mac_q      <= '0;
      cmp_q      <= '0;
      pcap_q     <= '0;
      lat_q      <= '0;
    end else begin
      // A tick during AGE wins over the clear, re-arming another sweep.
      if (age_tick)              age_pend_q <= 1'b1;
      else if (state_q == S_AGE) age_pend_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mac_q  <= learn_mac;
            cmp_q  <= learn_mac;
            pcap_q <= learn_port;
            lat_q  <= '0;
            del_q  <= WR_LEARN;
          end
        end
        S_LOOKUP: begin
          lat_q <= lat_q + 1'b1;
          if (lat_done) begin
            if (enc_found[ENC_HIT]) begin
              age_q[enc_idx[ENC_HIT]]  <= AGE_MAX;
              port_q[enc_idx[ENC_HIT]] <= pcap_q;
            end else if (enc_found[ENC_FREE]) begin
              tgt_q <= enc_idx[ENC_FREE];
            end else begin
              tgt_q    <= victim_q;
              victim_q <= victim_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_en) begin
            if (del_q) valid_q[tgt_q] <= 1'b0;
            else begin
              valid_q[tgt_q] <= 1'b1;
              age_q[tgt_q]   <= AGE_MAX;
              port_q[tgt_q]  <= pcap_q;
            end
          end
        end
        S_AGE: begin
          expired_q <= valid_q & age_zero;
          for (int i = 0; i < N; i++)
            if (valid_q[i] && !age_zero[i]) age_q[i] <= age_q[i] - 1'b1;
        end
        S_SCAN: begin
          if (enc_found[ENC_EXP]) begin
            tgt_q                       <= enc_idx[ENC_EXP];
            expired_q[enc_idx[ENC_EXP]] <= 1'b0;
            del_q                       <= WR_DELETE;
          end
        end
        default: ;
      endcase
    end
  end

  assign cam_write_enable = wr_en;
  assign cam_write_addr   = tgt_q;
  assign cam_write_delete = (state_q == S_WRITE) & del_q;
  assign cam_write_data   = ((state_q == S_WRITE) && !del_q) ? mac_q : '0;
  assign cam_compare_data = cmp_q;
  assign entry_valid      = valid_q;
  assign rd_port          = port_q[rd_addr];
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Directed bench for cam_learn_ctrl with a behavioural CAM (combinational match).
module tb_cam_learn_ctrl;

  logic        clk = 1'b0, rst = 1'b0;
  logic        learn_valid = 1'b0, learn_ready;
  logic [47:0] learn_mac = '0;
  logic [1:0]  learn_port = '0;
  logic        age_tick = 1'b0;
  logic [4:0]  cam_write_addr;
  logic [47:0] cam_write_data;
  logic        cam_write_delete, cam_write_enable;
  logic        cam_write_busy = 1'b0;
  logic [47:0] cam_compare_data;
  logic [31:0] cam_match_many, entry_valid;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  rd_port;
  logic        busy;

  cam_learn_ctrl dut (
    .clk(clk), .rst(rst), .learn_valid(learn_valid), .learn_ready(learn_ready),
    .learn_mac(learn_mac), .learn_port(learn_port), .age_tick(age_tick),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match_many(cam_match_many), .entry_valid(entry_valid),
    .rd_addr(rd_addr), .rd_port(rd_port), .busy(busy)
  );

  always #5 clk = ~clk;

  // CAM model: keys survive controller reset, which is what makes stale matches possible.
  logic [47:0] cam_key [32];
  logic [31:0] cam_v = '0;
  int          wr_cnt = 0;
  logic [4:0]  last_addr = '0, prev_addr = '0;
  logic        last_del = 1'b0, prev_del = 1'b0;

  always_comb begin
    cam_match_many = '0;
    for (int i = 0; i < 32; i++)
      if (cam_v[i] && cam_key[i] == cam_compare_data) cam_match_many[i] = 1'b1;
  end

  always @(posedge clk) begin
    if (cam_write_enable) begin
      wr_cnt    <= wr_cnt + 1;
      prev_addr <= last_addr;
      prev_del  <= last_del;
      last_addr <= cam_write_addr;
      last_del  <= cam_write_delete;
      if (cam_write_delete) cam_v[cam_write_addr] <= 1'b0;
      else begin
        cam_v[cam_write_addr]   <= 1'b1;
        cam_key[cam_write_addr] <= cam_write_data;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout("wait_idle");
  endtask

  task automatic learn(input logic [47:0] mac, input logic [1:0] p);
    int n = 0;
    while (!learn_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("learn_ready");
    learn_mac = mac; learn_port = p; learn_valid = 1'b1;
    @(negedge clk);
    learn_valid = 1'b0;
    wait_idle();
  endtask

  task automatic tick(output int cyc);
    cyc = 0;
    @(negedge clk) age_tick = 1'b1;
    @(negedge clk) age_tick = 1'b0;
    @(negedge clk);
    while (busy && cyc < 500) begin cyc++; @(negedge clk); end
    if (cyc >= 500) timeout("tick_sweep");
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  typedef struct {
    logic [47:0] mac;
    logic [1:0]  port;
    int          strobes;
    logic [4:0]  addr;
    logic [31:0] valid;
  } vec_t;

  vec_t vt [5];
  localparam logic [47:0] MAC_A = 48'h0000_1111_2222;
  localparam logic [47:0] MAC_B = 48'h0000_AAAA_0001;
  localparam logic [47:0] MAC_C = 48'h0000_BBBB_0002;
  localparam logic [47:0] MAC_W = 48'h0000_0C0C_0077;
  localparam logic [47:0] MAC_Z = 48'h0000_0D0D_0055;

  initial begin
    int c0, cyc, n;
    vt[0] = '{MAC_A, 2'd1, 1, 5'd0, 32'h1};
    vt[1] = '{MAC_A, 2'd3, 0, 5'd0, 32'h1};
    vt[2] = '{MAC_B, 2'd2, 1, 5'd1, 32'h3};
    vt[3] = '{MAC_B, 2'd0, 0, 5'd1, 32'h3};
    vt[4] = '{MAC_C, 2'd1, 1, 5'd2, 32'h7};

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", entry_valid, 0);
    chk("rst_ready", learn_ready, 0);
    chk("rst_wen", cam_write_enable, 0);
    chk("rst_cmp", cam_compare_data, 0);
    @(negedge clk); @(negedge clk) rst = 1'b1;
    #1 chk("post_rst_ready", learn_ready, 1);

    // Learn / re-learn table
    for (int k = 0; k < 5; k++) begin
      c0 = wr_cnt;
      learn(vt[k].mac, vt[k].port);
      chk("tbl_strobes", wr_cnt - c0, vt[k].strobes);
      if (vt[k].strobes != 0) begin
        chk("tbl_waddr", last_addr, vt[k].addr);
        chk("tbl_wdel", last_del, 0);
      end
      chk("tbl_valid", entry_valid, vt[k].valid);
      rd_addr = vt[k].addr;
      #1 chk("tbl_rd_port", rd_port, vt[k].port);
      chk("tbl_age", dut.age_q[vt[k].addr], 7);
    end

    // Fill remaining slots, then evict round-robin
    for (int i = 3; i < 32; i++) learn(48'h00C0_0000_0000 | 48'(i), 2'(i));
    chk("fill_valid", entry_valid, 32'hFFFF_FFFF);
    rd_addr = 5'd31;
    #1 chk("fill_rd_port31", rd_port, 3);
    c0 = wr_cnt;
    learn(48'h00D0_0000_0001, 2'd2);
    chk("evict1_strobes", wr_cnt - c0, 1);
    chk("evict1_addr", last_addr, 0);
    chk("evict1_victim", dut.victim_q, 1);
    learn(48'h00D0_0000_0002, 2'd1);
    chk("evict2_addr", last_addr, 1);
    chk("evict2_victim", dut.victim_q, 2);

    // Age out
    do_reset();
    chk("ageout_rst_valid", entry_valid, 0);
    tick(cyc);
    chk("empty_sweep_cycles", cyc, 2);
    learn(48'h0000_0A0A_0001, 2'd1);
    learn(48'h0000_0A0A_0002, 2'd2);
    chk("ageout_pre_valid", entry_valid, 32'h3);
    c0 = wr_cnt;
    for (int t = 0; t < 7; t++) tick(cyc);
    chk("ageout_7_valid", entry_valid, 32'h3);
    chk("ageout_7_strobes", wr_cnt - c0, 0);
    tick(cyc);
    chk("ageout_8_strobes", wr_cnt - c0, 2);
    chk("ageout_del0_addr", prev_addr, 0);
    chk("ageout_del0_flag", prev_del, 1);
    chk("ageout_del1_addr", last_addr, 1);
    chk("ageout_del1_flag", last_del, 1);
    chk("ageout_valid", entry_valid, 0);

    // Contention: tick and learn in the same IDLE cycle
    @(negedge clk);
    learn_mac = MAC_Z; learn_port = 2'd2; learn_valid = 1'b1; age_tick = 1'b1;
    #1 chk("contend_ready", learn_ready, 0);
    @(negedge clk) age_tick = 1'b0;
    #1 chk("contend_pend_ready", learn_ready, 0);
    @(negedge clk);
    chk("contend_sweep_busy", busy, 1);
    chk("contend_not_captured", cam_compare_data == MAC_Z, 0);
    n = 0;
    while (!learn_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("contend_accept");
    c0 = wr_cnt;
    @(negedge clk) learn_valid = 1'b0;
    wait_idle();
    chk("contend_cmp", cam_compare_data, MAC_Z);
    chk("contend_strobes", wr_cnt - c0, 1);
    chk("contend_valid", entry_valid, 32'h1);

    // Tick during SCAN re-arms a second sweep (age 7 -> 5)
    @(negedge clk) age_tick = 1'b1;
    @(negedge clk) age_tick = 1'b0;
    @(negedge clk);
    @(negedge clk) age_tick = 1'b1;
    chk("scan_busy", busy, 1);
    @(negedge clk) age_tick = 1'b0;
    @(negedge clk);
    wait_idle();
    chk("rearm_age", dut.age_q[0], 5);
    chk("rearm_valid", entry_valid, 32'h1);

    // Busy stall, reset inside WAIT, stale CAM match
    @(negedge clk);
    c0 = wr_cnt;
    cam_write_busy = 1'b1;
    learn_mac = MAC_W; learn_port = 2'd1; learn_valid = 1'b1;
    @(negedge clk) learn_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stall_strobes", wr_cnt - c0, 0);
    chk("stall_wen", cam_write_enable, 0);
    chk("stall_busy", busy, 1);
    cam_write_busy = 1'b0;
    #1 chk("stall_release_wen", cam_write_enable, 1);
    chk("stall_release_addr", cam_write_addr, 1);
    chk("stall_release_data", cam_write_data, MAC_W);
    @(negedge clk) cam_write_busy = 1'b1;
    chk("stall_strobe_once", wr_cnt - c0, 1);
    chk("wait_valid", entry_valid, 32'h3);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", entry_valid, 0);
    chk("midrst_ready", learn_ready, 0);
    @(negedge clk);
    cam_write_busy = 1'b0;
    rst = 1'b1;
    c0 = wr_cnt;
    learn(MAC_W, 2'd2);
    chk("stale_miss_strobes", wr_cnt - c0, 1);
    chk("stale_miss_addr", last_addr, 0);
    chk("stale_miss_valid", entry_valid, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
